acs_unit: RTL and testbench

Add-compare-select stage of the K=3, rate-1/2 hard-decision Viterbi decoder, with the branch-metric computation built in. It takes one received 2-bit code symbol per `valid_i` and updates the four state path metrics. For each state it emits the survivor decision bits and the normalized path metrics, which drive `tbu` directly. Metrics are renormalized every step so they never overflow `PM_WIDTH`.

---
 rtl/acs_unit.sv | 136 +++++++++++++
 tb/tb_acs_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_unit.sv
// acs_unit: add-compare-select stage of a K=3, rate-1/2 hard-decision Viterbi
// decoder, with the branch metrics computed in the same cycle.
// Each valid received symbol updates the four state path metrics. The block
// records one survivor decision per state and renormalises the metrics so
// that the smallest one is always 0.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   valid_i     rx_sym_i carries a symbol this cycle
//   sof_i       start of frame; the metrics restart from the init values
//   rx_sym_i    received symbol, [0] = code bit 0, [1] = code bit 1
//   dec_bits_o  survivor decision per state (1 = higher-indexed predecessor)
//   pm_s0_o..pm_s3_o  registered, normalised path metrics
//   valid_o     one-cycle pulse after each symbol update
module acs_unit #(
  parameter int unsigned PM_WIDTH = 8,
  parameter int unsigned INIT_PM  = 2**(PM_WIDTH-2),
  parameter logic [2:0]  G0       = 3'b111,
  parameter logic [2:0]  G1       = 3'b101
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                sof_i,
  input  logic [1:0]          rx_sym_i,
  output logic [3:0]          dec_bits_o,
  output logic [PM_WIDTH-1:0] pm_s0_o,
  output logic [PM_WIDTH-1:0] pm_s1_o,
  output logic [PM_WIDTH-1:0] pm_s2_o,
  output logic [PM_WIDTH-1:0] pm_s3_o,
  output logic                valid_o
);

  localparam int unsigned          CW      = PM_WIDTH + 1;
  localparam logic [PM_WIDTH-1:0]  LP_INIT = PM_WIDTH'(INIT_PM);

  // Hamming distance between the expected code pair for taps {u, p[1], p[0]}
  // and the received symbol.
  function automatic logic [1:0] branch_metric(input logic [2:0] taps,
                                               input logic [1:0] rx);
    logic c0;
    logic c1;
    c0 = ^(G0 & taps);
    c1 = ^(G1 & taps);
    return {1'b0, c0 ^ rx[0]} + {1'b0, c1 ^ rx[1]};
  endfunction

  logic [PM_WIDTH-1:0] r_pm [4];
  logic [3:0]          r_dec;
  logic                r_valid;

  logic [PM_WIDTH-1:0] w_base [4];
  logic [CW-1:0]       w_surv [4];
  logic [PM_WIDTH-1:0] w_norm [4];
  logic [3:0]          w_dec;
  logic [CW-1:0]       w_min01;
  logic [CW-1:0]       w_min23;
  logic [CW-1:0]       w_min;

  // A start-of-frame symbol is decoded against the init metrics rather than
  // against whatever the previous frame left behind.
  always_comb begin
    if (sof_i && valid_i) begin
      w_base[0] = '0;
      w_base[1] = LP_INIT;
      w_base[2] = LP_INIT;
      w_base[3] = LP_INIT;
    end else begin
      w_base[0] = r_pm[0];
      w_base[1] = r_pm[1];
      w_base[2] = r_pm[2];
      w_base[3] = r_pm[3];
    end
  end

  // State s = {newest bit, previous bit}. Its predecessors are {s[0], 0}
  // and {s[0], 1} with input u = s[1], so the encoder taps {u, p} for each
  // branch are just {s, k}.
  for (genvar gs = 0; gs < 4; gs++) begin : g_acs
    localparam logic [1:0] S    = 2'(gs);
    localparam logic [1:0] P_LO = {S[0], 1'b0};
    localparam logic [1:0] P_HI = {S[0], 1'b1};

    logic [CW-1:0] w_cand_lo;
    logic [CW-1:0] w_cand_hi;
    logic [CW-1:0] w_diff;

    assign w_cand_lo = {1'b0, w_base[P_LO]} + CW'(branch_metric({S[1], P_LO}, rx_sym_i));
    assign w_cand_hi = {1'b0, w_base[P_HI]} + CW'(branch_metric({S[1], P_HI}, rx_sym_i));

    // Ties go to the lower-indexed predecessor.
    assign w_dec[gs]  = (w_cand_hi < w_cand_lo);
    assign w_surv[gs] = w_dec[gs] ? w_cand_hi : w_cand_lo;

    assign w_diff      = w_surv[gs] - w_min;
    assign w_norm[gs]  = w_diff[PM_WIDTH] ? '1 : w_diff[PM_WIDTH-1:0];
  end

  assign w_min01 = (w_surv[0] <= w_surv[1]) ? w_surv[0] : w_surv[1];
  assign w_min23 = (w_surv[2] <= w_surv[3]) ? w_surv[2] : w_surv[3];
  assign w_min   = (w_min01 <= w_min23) ? w_min01 : w_min23;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm[0] <= '0;
      r_pm[1] <= LP_INIT;
      r_pm[2] <= LP_INIT;
      r_pm[3] <= LP_INIT;
      r_dec   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
          r_pm[i] <= w_norm[i];
        end
        r_dec <= w_dec;
      end else if (sof_i) begin
        // Frame restart without a symbol: reload metrics, decisions hold.
        r_pm[0] <= '0;
        r_pm[1] <= LP_INIT;
        r_pm[2] <= LP_INIT;
        r_pm[3] <= LP_INIT;
      end
    end
  end

  assign pm_s0_o    = r_pm[0];
  assign pm_s1_o    = r_pm[1];
  assign pm_s2_o    = r_pm[2];
  assign pm_s3_o    = r_pm[3];
  assign dec_bits_o = r_dec;
  assign valid_o    = r_valid;

endmodule

// File: tb/tb_acs_unit.sv
// tb_acs_unit: directed, self-checking bench for acs_unit with the default
// (7,5) code, PM_WIDTH=8 and INIT_PM=64. The expected metrics below were
// worked out by hand through the trellis.
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       sof_i;
  logic [1:0] rx_sym_i;
  logic [3:0] dec_bits_o;
  logic [7:0] pm_s0_o;
  logic [7:0] pm_s1_o;
  logic [7:0] pm_s2_o;
  logic [7:0] pm_s3_o;
  logic       valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acs_unit #(
    .PM_WIDTH(8),
    .INIT_PM (64),
    .G0      (3'b111),
    .G1      (3'b101)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .sof_i     (sof_i),
    .rx_sym_i  (rx_sym_i),
    .dec_bits_o(dec_bits_o),
    .pm_s0_o   (pm_s0_o),
    .pm_s1_o   (pm_s1_o),
    .pm_s2_o   (pm_s2_o),
    .pm_s3_o   (pm_s3_o),
    .valid_o   (valid_o)
  );

  logic [31:0] pm_all;
  assign pm_all = {pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o};

  localparam logic [31:0] PM_INIT    = {8'd0, 8'd64, 8'd64, 8'd64};
  localparam logic [31:0] PM_FIRST00 = {8'd0, 8'd65, 8'd2, 8'd65};
  localparam logic [31:0] PM_ZERO_SS = {8'd0, 8'd3, 8'd2, 8'd3};

  // Input 1,0,1,1,0,0 encoded with (7,5) gives 11,01,00,10,10,11; the
  // third symbol is received as 01 (bit 0 flipped).
  logic [1:0]  enc_rx  [6] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [31:0] enc_pm  [6] = '{{8'd2, 8'd65, 8'd0, 8'd65},
                               {8'd3, 8'd0,  8'd3, 8'd2},
                               {8'd0, 8'd2,  8'd0, 8'd1},
                               {8'd1, 8'd1,  8'd1, 8'd0},
                               {8'd2, 8'd0,  8'd2, 8'd1},
                               {8'd0, 8'd2,  8'd2, 8'd2}};
  logic [3:0]  enc_dec [6] = '{4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0010, 4'b1011};
  int unsigned enc_st  [6] = '{2, 1, 2, 3, 1, 0};
  logic [1:0]  rnd_rx  [10] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01,
                                2'b11, 2'b10, 2'b00, 2'b11, 2'b01};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; valid_i = 1'b0; sof_i = 1'b0; rx_sym_i = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; sof_i = 1'b1; rx_sym_i = 2'b11;
    tick();
    tick();
    rst = 1'b0; valid_i = 1'b0; sof_i = 1'b0;
    checks++;
    if (pm_all !== PM_INIT) begin
      errors++; $display("FAIL reset_pm: got %h expected %h", pm_all, PM_INIT);
    end
    checks++;
    if (dec_bits_o !== 4'b0000) begin
      errors++; $display("FAIL reset_dec: got %b expected 0000", dec_bits_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
  endtask

  task automatic test_first_symbol();
    valid_i = 1'b1; rx_sym_i = 2'b00;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++; $display("FAIL first_valid: got %b expected 1", valid_o);
    end
    checks++;
    if (pm_all !== PM_FIRST00) begin
      errors++; $display("FAIL first_pm: got %h expected %h", pm_all, PM_FIRST00);
    end
    checks++;
    if (dec_bits_o !== 4'b0000) begin
      errors++; $display("FAIL first_dec: got %b expected 0000", dec_bits_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || pm_all !== PM_FIRST00) begin
      errors++; $display("FAIL first_hold: got valid=%b pm=%h expected valid=0 pm=%h",
                         valid_o, pm_all, PM_FIRST00);
    end
  endtask

  task automatic test_all_zero();
    apply_reset();
    valid_i = 1'b1; rx_sym_i = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (pm_s0_o !== 8'd0 || dec_bits_o[0] !== 1'b0 || valid_o !== 1'b1) begin
        errors++; $display("FAIL zero_stream[%0d]: got pm0=%0d dec0=%b valid=%b expected 0,0,1",
                           i, pm_s0_o, dec_bits_o[0], valid_o);
      end
    end
    valid_i = 1'b0;
    checks++;
    if (pm_all !== PM_ZERO_SS || dec_bits_o !== 4'b0000) begin
      errors++; $display("FAIL zero_final: got pm=%h dec=%b expected pm=%h dec=0000",
                         pm_all, dec_bits_o, PM_ZERO_SS);
    end
  endtask

  task automatic test_encoded_error();
    logic [7:0] pm_arr [4];
    logic [7:0] mx;
    logic [7:0] mn;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1; rx_sym_i = enc_rx[i];
      tick();
      pm_arr[0] = pm_s0_o; pm_arr[1] = pm_s1_o; pm_arr[2] = pm_s2_o; pm_arr[3] = pm_s3_o;
      checks++;
      if (pm_all !== enc_pm[i] || dec_bits_o !== enc_dec[i]) begin
        errors++; $display("FAIL enc_step[%0d]: got pm=%h dec=%b expected pm=%h dec=%b",
                           i, pm_all, dec_bits_o, enc_pm[i], enc_dec[i]);
      end
      checks++;
      if (pm_arr[enc_st[i]] !== 8'd0) begin
        errors++; $display("FAIL enc_min_state[%0d]: got pm[s%0d]=%0d expected 0",
                           i, enc_st[i], pm_arr[enc_st[i]]);
      end
      mx = pm_arr[0]; mn = pm_arr[0];
      for (int k = 1; k < 4; k++) begin
        if (pm_arr[k] > mx) mx = pm_arr[k];
        if (pm_arr[k] < mn) mn = pm_arr[k];
      end
      checks++;
      if (mx - mn > 8'd66) begin
        errors++; $display("FAIL enc_spread[%0d]: got %0d expected <= 66", i, mx - mn);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_gapped();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1; rx_sym_i = enc_rx[i];
      tick();
      valid_i = 1'b0; rx_sym_i = ~enc_rx[i];
      checks++;
      if (valid_o !== 1'b1 || pm_all !== enc_pm[i]) begin
        errors++; $display("FAIL gap_step[%0d]: got valid=%b pm=%h expected valid=1 pm=%h",
                           i, valid_o, pm_all, enc_pm[i]);
      end
      for (int g = 0; g < 3; g++) begin
        tick();
        checks++;
        if (valid_o !== 1'b0 || pm_all !== enc_pm[i] || dec_bits_o !== enc_dec[i]) begin
          errors++; $display("FAIL gap_hold[%0d.%0d]: got valid=%b pm=%h dec=%b expected valid=0 pm=%h dec=%b",
                             i, g, valid_o, pm_all, dec_bits_o, enc_pm[i], enc_dec[i]);
        end
      end
    end
    checks++;
    if (pm_all !== enc_pm[5]) begin
      errors++; $display("FAIL gap_final: got %h expected %h", pm_all, enc_pm[5]);
    end
  endtask

  task automatic test_sof();
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; rx_sym_i = rnd_rx[i];
      tick();
    end
    sof_i = 1'b1; valid_i = 1'b1; rx_sym_i = 2'b00;
    tick();
    sof_i = 1'b0;
    checks++;
    if (pm_all !== PM_FIRST00 || dec_bits_o !== 4'b0000 || valid_o !== 1'b1) begin
      errors++; $display("FAIL sof_valid: got pm=%h dec=%b valid=%b expected pm=%h dec=0000 valid=1",
                         pm_all, dec_bits_o, valid_o, PM_FIRST00);
    end
    // Restart the frame on the encoded sequence to leave known decisions.
    for (int i = 0; i < 6; i++) begin
      sof_i = (i == 0); valid_i = 1'b1; rx_sym_i = enc_rx[i];
      tick();
    end
    sof_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (pm_all !== enc_pm[5] || dec_bits_o !== enc_dec[5]) begin
      errors++; $display("FAIL sof_frame: got pm=%h dec=%b expected pm=%h dec=%b",
                         pm_all, dec_bits_o, enc_pm[5], enc_dec[5]);
    end
    sof_i = 1'b1;
    tick();
    sof_i = 1'b0;
    checks++;
    if (pm_all !== PM_INIT || dec_bits_o !== 4'b1011 || valid_o !== 1'b0) begin
      errors++; $display("FAIL sof_only: got pm=%h dec=%b valid=%b expected pm=%h dec=1011 valid=0",
                         pm_all, dec_bits_o, valid_o, PM_INIT);
    end
    valid_i = 1'b1; rx_sym_i = 2'b00;
    tick();
    valid_i = 1'b0;
    checks++;
    if (pm_all !== PM_FIRST00 || valid_o !== 1'b1) begin
      errors++; $display("FAIL sof_only_next: got pm=%h valid=%b expected pm=%h valid=1",
                         pm_all, valid_o, PM_FIRST00);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; rx_sym_i = enc_rx[i];
      tick();
    end
    rst = 1'b1; valid_i = 1'b1; sof_i = 1'b0; rx_sym_i = 2'b11;
    tick();
    checks++;
    if (pm_all !== PM_INIT || dec_bits_o !== 4'b0000 || valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got pm=%h dec=%b valid=%b expected pm=%h dec=0000 valid=0",
                         pm_all, dec_bits_o, valid_o, PM_INIT);
    end
    rst = 1'b0; valid_i = 1'b1; rx_sym_i = 2'b00;
    tick();
    valid_i = 1'b0;
    checks++;
    if (pm_all !== PM_FIRST00 || dec_bits_o !== 4'b0000 || valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_resume: got pm=%h dec=%b valid=%b expected pm=%h dec=0000 valid=1",
                         pm_all, dec_bits_o, valid_o, PM_FIRST00);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_resume_pulse: got valid=%b expected 0", valid_o);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; sof_i = 1'b0; rx_sym_i = 2'b00;
    test_reset();
    test_first_symbol();
    test_all_zero();
    test_encoded_error();
    test_gapped();
    test_sof();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
